// File: rtl/bp_fe_queue_buffer_pkg.sv
// Shared types for the FE queue buffer: processor config selector and the
// FE-to-BE queue message layout.
package bp_fe_queue_buffer_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_inv_cfg
  } bp_params_e;

  typedef enum logic [1:0] {
    e_fe_fetch,
    e_fe_exception
  } bp_fe_queue_type_e;

  localparam int unsigned vaddr_width_gp = 39;
  localparam int unsigned instr_width_gp = 32;

  typedef struct packed {
    bp_fe_queue_type_e           msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  // Unknown configurations yield a zero width so a bad override fails elaboration.
  function automatic int unsigned fe_queue_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg, e_bp_inv_cfg: return $bits(bp_fe_queue_s);
      default:                        return 0;
    endcase
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write-port, one-asynchronous-read-port storage array without reset.
module bsg_mem_1r1w #(
  parameter int unsigned width_p                = 8,
  parameter int unsigned els_p                  = 8,
  parameter bit          read_write_same_addr_p = 1'b0,
  localparam int unsigned addr_width_lp         = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i)
      mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

  always_ff @(posedge w_clk_i) begin
    if (!read_write_same_addr_p)
      assert (!(w_v_i && r_v_i && (w_addr_i == r_addr_i)))
        else $error("bsg_mem_1r1w: write collides with a valid read address");
  end

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// Checkpointed FIFO between the FE PC generator and BE issue: speculative
// dequeue with commit, rollback to the commit point, and clear.
module bp_fe_queue_buffer
  import bp_fe_queue_buffer_pkg::*;
#(
  parameter bp_params_e  bp_params_p        = e_bp_inv_cfg,
  parameter int unsigned els_p              = 8,
  localparam int unsigned fe_queue_width_lp = fe_queue_width(bp_params_p),
  localparam int unsigned ptr_width_lp      = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_cmt_v_i,
  input  logic                         fe_queue_roll_v_i,
  input  logic                         fe_queue_clr_v_i,
  output logic                         empty_o
);

  localparam int unsigned addr_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic full, enq, mem_w_v;

  // Full is measured against the commit pointer so replay data is never overwritten.
  assign full = (wptr_r[addr_width_lp-1:0] == cptr_r[addr_width_lp-1:0])
              & (wptr_r[addr_width_lp] != cptr_r[addr_width_lp]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_r != wptr_r);
  assign empty_o          = (rptr_r == wptr_r);
  assign enq              = fe_queue_v_i & fe_queue_ready_o;
  assign mem_w_v          = enq & ~fe_queue_clr_v_i;

  // Priority: commit, roll, dequeue, clear, enqueue.
  always_comb begin
    cptr_n = cptr_r + ptr_width_lp'(fe_queue_cmt_v_i);
    rptr_n = fe_queue_roll_v_i ? cptr_n : rptr_r + ptr_width_lp'(fe_queue_yumi_i);
    wptr_n = fe_queue_clr_v_i  ? rptr_n : wptr_r + ptr_width_lp'(enq);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p                (fe_queue_width_lp),
    .els_p                  (els_p),
    .read_write_same_addr_p (1'b0)
  ) queue_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (wptr_r[addr_width_lp-1:0]),
    .w_data_i (fe_queue_i),
    .r_v_i    (fe_queue_v_o),
    .r_addr_i (rptr_r[addr_width_lp-1:0]),
    .r_data_o (fe_queue_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("bp_fe_queue_buffer: yumi with no valid entry");
      assert (!(fe_queue_cmt_v_i && (cptr_r == rptr_r)))
        else $error("bp_fe_queue_buffer: commit with nothing dequeued");
      assert (!(fe_queue_v_i && !fe_queue_ready_o))
        else $error("bp_fe_queue_buffer: enqueue while not ready");
    end
  end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer with a queue-based reference model.
module tb_bp_fe_queue_buffer;
  import bp_fe_queue_buffer_pkg::*;

  localparam int unsigned W   = $bits(bp_fe_queue_s);
  localparam int          ELS = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_cmt_v_i;
  logic         fe_queue_roll_v_i;
  logic         fe_queue_clr_v_i;
  logic         empty_o;

  int checks = 0;
  int errors = 0;

  // Entries from the commit point to the write point; the first ndeq are dequeued.
  bp_fe_queue_s sb[$];
  int ndeq = 0;

  bp_fe_queue_s held [5];

  bp_fe_queue_buffer #(
    .bp_params_p (e_bp_inv_cfg),
    .els_p       (ELS)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .fe_queue_i        (fe_queue_i),
    .fe_queue_v_i      (fe_queue_v_i),
    .fe_queue_ready_o  (fe_queue_ready_o),
    .fe_queue_o        (fe_queue_o),
    .fe_queue_v_o      (fe_queue_v_o),
    .fe_queue_yumi_i   (fe_queue_yumi_i),
    .fe_queue_cmt_v_i  (fe_queue_cmt_v_i),
    .fe_queue_roll_v_i (fe_queue_roll_v_i),
    .fe_queue_clr_v_i  (fe_queue_clr_v_i),
    .empty_o           (empty_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bp_fe_queue_s mk(input logic [38:0] pc);
    bp_fe_queue_s m;
    m.msg_type = e_fe_fetch;
    m.pc       = pc;
    m.instr    = pc[31:0] ^ 32'hdeadbeef;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".ready"}, W'(fe_queue_ready_o), W'(sb.size() < ELS));
    chk({where, ".valid"}, W'(fe_queue_v_o),     W'(ndeq < sb.size()));
    chk({where, ".empty"}, W'(empty_o),          W'(ndeq == sb.size()));
    if (ndeq < sb.size())
      chk({where, ".data"}, fe_queue_o, sb[ndeq]);
  endtask

  task automatic drive_idle();
    fe_queue_v_i      = 1'b0;
    fe_queue_i        = '0;
    fe_queue_yumi_i   = 1'b0;
    fe_queue_cmt_v_i  = 1'b0;
    fe_queue_roll_v_i = 1'b0;
    fe_queue_clr_v_i  = 1'b0;
  endtask

  task automatic step(input string where, input logic v, input bp_fe_queue_s d,
                      input logic y, input logic cm, input logic rl, input logic cl);
    bit rdy;
    rdy               = (sb.size() < ELS);
    fe_queue_v_i      = v;
    fe_queue_i        = d;
    fe_queue_yumi_i   = y;
    fe_queue_cmt_v_i  = cm;
    fe_queue_roll_v_i = rl;
    fe_queue_clr_v_i  = cl;
    @(posedge clk_i);
    if (cm && sb.size() > 0) begin
      void'(sb.pop_front());
      ndeq--;
    end
    if (rl)     ndeq = 0;
    else if (y) ndeq++;
    if (cl) begin
      while (sb.size() > ndeq) void'(sb.pop_back());
    end else if (v && rdy) begin
      sb.push_back(d);
    end
    #1;
    check_outputs(where);
  endtask

  task automatic enq(input string where, input bp_fe_queue_s d);
    step(where, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic deq(input string where);
    step(where, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic cmt(input string where);
    step(where, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic idle(input string where);
    step(where, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive_idle();
    reset_i = 1'b0;
    #1;
    check_outputs("reset");
    @(negedge clk_i);
    reset_i = 1'b1;

    // Message A enqueued in cycle 3 shows up the following cycle.
    idle("idle1");
    idle("idle2");
    enq("enqA", mk(39'h80000000));
    deq("deqA");
    cmt("cmtA");

    // Full counts uncommitted entries.
    for (int i = 0; i < ELS; i++) enq("fill", mk(39'h80001000 + 39'(i * 4)));
    for (int i = 0; i < ELS; i++) deq("drain");
    cmt("cmt_after_full");
    for (int i = 1; i < ELS; i++) cmt("cmt_rest");

    // Rollback replays from the oldest uncommitted entry.
    enq("rbA", mk(39'h80002000));
    enq("rbB", mk(39'h80002004));
    enq("rbC", mk(39'h80002008));
    deq("rb_deqA");
    deq("rb_deqB");
    cmt("rb_cmtA");
    step("rb_roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    deq("rb_deqB2");
    deq("rb_deqC");
    cmt("rb_cmtB");
    cmt("rb_cmtC");

    // Clear drops un-dequeued entries and a same-cycle enqueue.
    enq("clA", mk(39'h80003000));
    enq("clB", mk(39'h80003004));
    enq("clC", mk(39'h80003008));
    enq("clD", mk(39'h8000300c));
    deq("cl_deqA");
    step("cl_clr_enqE", 1'b1, mk(39'h80003010), 1'b0, 1'b0, 1'b0, 1'b1);
    step("cl_roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    deq("cl_deqA2");
    cmt("cl_cmtA");

    // Pointer wrap-around with ordered traffic.
    for (int i = 0; i < 20; i++) begin
      enq("wrap_enq", mk(39'h80004000 + 39'($urandom_range(0, 4095) * 4)));
      deq("wrap_deq");
      cmt("wrap_cmt");
    end
    for (int i = 0; i < ELS; i++) enq("wrap_fill", mk(39'h80005000 + 39'(i * 4)));
    for (int i = 0; i < ELS; i++) deq("wrap_drain");
    for (int i = 0; i < ELS; i++) cmt("wrap_cmt_all");

    // Asynchronous reset with entries held.
    for (int i = 0; i < 5; i++) begin
      held[i] = mk(39'h80006000 + 39'(i * 4));
      enq("hold", held[i]);
    end
    deq("hold_deq0");
    deq("hold_deq1");
    drive_idle();
    #2;
    reset_i = 1'b0;
    sb.delete();
    ndeq = 0;
    #1;
    check_outputs("async_reset");
    @(negedge clk_i);
    reset_i = 1'b1;
    enq("post_reset_enq", mk(39'h80007000));
    chk("post_reset_sole", W'(sb.size()), W'(1));
    deq("post_reset_deq");
    cmt("post_reset_cmt");

    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
